// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: arbiter state encoding and default frame-RAM port widths
package ram_port_arbiter_pkg;
    localparam int ARB_ADDR_W = 15;
    localparam int ARB_DATA_W = 8;
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: two requester ports plus RAM port B; slave = arbiter view, master = environment view
interface ram_port_arbiter_if #(
    parameter int ADDR_W = ram_port_arbiter_pkg::ARB_ADDR_W,
    parameter int DATA_W = ram_port_arbiter_pkg::ARB_DATA_W
);
    logic              Req0, Req1, We0, We1;
    logic              Gnt0, Gnt1, Rvalid0, Rvalid1;
    logic [ADDR_W-1:0] Addr0, Addr1, RAM_Addr;
    logic [DATA_W-1:0] Wdata0, Wdata1, Rdata0, Rdata1;
    logic [DATA_W-1:0] RAM_Write_Data, RAM_Read_Data;
    logic              RAM_Write_En;

    modport slave (
        input  Req0, Req1, We0, We1, Addr0, Addr1, Wdata0, Wdata1, RAM_Read_Data,
        output Gnt0, Gnt1, Rvalid0, Rvalid1, Rdata0, Rdata1,
               RAM_Addr, RAM_Write_Data, RAM_Write_En
    );

    modport master (
        output Req0, Req1, We0, We1, Addr0, Addr1, Wdata0, Wdata1, RAM_Read_Data,
        input  Gnt0, Gnt1, Rvalid0, Rvalid1, Rdata0, Rdata1,
               RAM_Addr, RAM_Write_Data, RAM_Write_En
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin, burst-locked sharing of RAM port B between two requesters.
// Optional per-requester beat counters with RAM_ARB_STATS_EN.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int DATA_W    = ARB_DATA_W,
    parameter int MAX_BURST = 16
) (
    input  logic               Clk,
    input  logic               Rst,
`ifdef RAM_ARB_STATS_EN
    input  logic               Stats_Clr,
    output logic [15:0]        Beat_Cnt0,
    output logic [15:0]        Beat_Cnt1,
`endif
    ram_port_arbiter_if.slave  bus
);
    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    arb_state_e        state_q, state_d, oth_st;
    logic              last_q, last_d;
    logic [7:0]        cnt_q, cnt_d, cnt_inc;
    logic              own1, own_req, oth_req;
    logic              gnt0, gnt1;
    logic              rv0_q, rv0_d, rv1_q, rv1_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
`ifdef RAM_ARB_STATS_EN
    logic [15:0]       bc0_q, bc0_d, bc1_q, bc1_d;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ARB_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
`ifdef RAM_ARB_STATS_EN
            bc0_q   <= '0;
            bc1_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
`ifdef RAM_ARB_STATS_EN
            bc0_q   <= bc0_d;
            bc1_q   <= bc1_d;
`endif
        end
    end

    // OWN0 and OWN1 are mirror images, so evaluate them through owner/other aliases
    always_comb begin
        own1    = state_q == ARB_OWN1;
        own_req = own1 ? bus.Req1 : bus.Req0;
        oth_req = own1 ? bus.Req0 : bus.Req1;
        oth_st  = own1 ? ARB_OWN0 : ARB_OWN1;
        cnt_inc = cnt_q + 8'd1;
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (state_q == ARB_IDLE) begin
            state_d = (bus.Req0 && bus.Req1) ? (last_q ? ARB_OWN0 : ARB_OWN1) :
                      bus.Req0 ? ARB_OWN0 : bus.Req1 ? ARB_OWN1 : ARB_IDLE;
        end else if (own_req) begin
            cnt_d = (cnt_inc == MAX_B) ? '0 : cnt_inc;
            if (cnt_inc == MAX_B && oth_req) begin
                state_d = oth_st;
                last_d  = own1;
            end
        end else begin
            state_d = oth_req ? oth_st : ARB_IDLE;
            last_d  = own1;
            cnt_d   = '0;
        end
    end

    always_comb begin
        gnt0    = state_q == ARB_OWN0 && bus.Req0;
        gnt1    = state_q == ARB_OWN1 && bus.Req1;
        addr_d  = gnt0 ? bus.Addr0 : gnt1 ? bus.Addr1 : '0;
        wdata_d = gnt0 ? bus.Wdata0 : gnt1 ? bus.Wdata1 : '0;
        rv0_d   = gnt0 && !bus.We0;
        rv1_d   = gnt1 && !bus.We1;
        bus.Gnt0           = gnt0;
        bus.Gnt1           = gnt1;
        bus.RAM_Addr       = addr_d;
        bus.RAM_Write_Data = wdata_d;
        bus.RAM_Write_En   = (gnt0 && bus.We0) || (gnt1 && bus.We1);
        bus.Rvalid0        = rv0_q;
        bus.Rvalid1        = rv1_q;
        bus.Rdata0         = bus.RAM_Read_Data;
        bus.Rdata1         = bus.RAM_Read_Data;
`ifdef RAM_ARB_STATS_EN
        bc0_d = Stats_Clr ? '0 : bc0_q + {15'd0, gnt0};
        bc1_d = Stats_Clr ? '0 : bc1_q + {15'd0, gnt1};
`endif
    end

`ifdef RAM_ARB_STATS_EN
    assign Beat_Cnt0 = bc0_q;
    assign Beat_Cnt1 = bc1_q;
`endif
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed stimulus against an owner/queue-level arbiter model and a RAM model
module tb_ram_port_arbiter;
    localparam int MAXB = 16;

    typedef struct {
        int own;
        int last;
        int run;
        bit rv0;
        bit rv1;
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   g0_seen = 0;
    int   g1_seen = 0;
    mdl_t m = '{-1, 1, 0, 1'b0, 1'b0};
    logic [7:0] m_rd0 = 8'h00, m_rd1 = 8'h00;
    logic [7:0] ram_rd = 8'h00;
    bit   [7:0] mem [32768];
    bit         memw [32768];
    bit   [7:0] sh [32768];
    bit         shw [32768];
`ifdef RAM_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] beat_cnt0, beat_cnt1;
    logic [15:0] m_bc0 = 16'h0, m_bc1 = 16'h0;
`endif

    ram_port_arbiter_if bus ();

    ram_port_arbiter #(.MAX_BURST(MAXB)) dut (
        .Clk       (clk),
        .Rst       (rst),
`ifdef RAM_ARB_STATS_EN
        .Stats_Clr (stats_clr),
        .Beat_Cnt0 (beat_cnt0),
        .Beat_Cnt1 (beat_cnt1),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Unwritten RAM locations hold a fixed address-derived pattern
    function automatic logic [7:0] pat(input logic [14:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] rdmem(input logic [14:0] a);
        return memw[a] ? mem[a] : pat(a);
    endfunction

    function automatic logic [7:0] rdsh(input logic [14:0] a);
        return shw[a] ? sh[a] : pat(a);
    endfunction

    always @(posedge clk) begin
        ram_rd <= rdmem(bus.RAM_Addr);
        if (bus.RAM_Write_En) begin
            mem[bus.RAM_Addr]  <= bus.RAM_Write_Data;
            memw[bus.RAM_Addr] <= 1'b1;
        end
    end
    assign bus.RAM_Read_Data = ram_rd;

    // Owner-level view: who owns the port, who was served last, beats in the current run
    function automatic mdl_t nxt(input mdl_t s, input bit r0, input bit r1, input bit w0, input bit w1);
        mdl_t n;
        bit hold, other;
        n = s;
        n.rv0 = s.own == 0 && r0 && !w0;
        n.rv1 = s.own == 1 && r1 && !w1;
        if (s.own < 0) begin
            n.own = (r0 && r1) ? 1 - s.last : r0 ? 0 : r1 ? 1 : -1;
        end else begin
            hold  = s.own == 0 ? r0 : r1;
            other = s.own == 0 ? r1 : r0;
            if (!hold) begin
                n.last = s.own;
                n.run  = 0;
                n.own  = other ? 1 - s.own : -1;
            end else if (s.run + 1 == MAXB) begin
                n.run = 0;
                if (other) begin
                    n.last = s.own;
                    n.own  = 1 - s.own;
                end
            end else begin
                n.run = s.run + 1;
            end
        end
        return n;
    endfunction

    function automatic bit eg(input int n);
        return m.own == n && (n == 0 ? bus.Req0 : bus.Req1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= '{-1, 1, 0, 1'b0, 1'b0};
`ifdef RAM_ARB_STATS_EN
            m_bc0 <= 16'h0;
            m_bc1 <= 16'h0;
`endif
        end else begin
            m <= nxt(m, bus.Req0, bus.Req1, bus.We0, bus.We1);
            if (eg(0)) begin
                if (bus.We0) begin
                    sh[bus.Addr0]  <= bus.Wdata0;
                    shw[bus.Addr0] <= 1'b1;
                end else m_rd0 <= rdsh(bus.Addr0);
            end
            if (eg(1)) begin
                if (bus.We1) begin
                    sh[bus.Addr1]  <= bus.Wdata1;
                    shw[bus.Addr1] <= 1'b1;
                end else m_rd1 <= rdsh(bus.Addr1);
            end
`ifdef RAM_ARB_STATS_EN
            m_bc0 <= stats_clr ? 16'h0 : m_bc0 + 16'(eg(0));
            m_bc1 <= stats_clr ? 16'h0 : m_bc1 + 16'(eg(1));
`endif
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("gnt0", {31'd0, bus.Gnt0}, {31'd0, eg(0)});
        chk("gnt1", {31'd0, bus.Gnt1}, {31'd0, eg(1)});
        chk("ram_we", {31'd0, bus.RAM_Write_En},
            {31'd0, eg(0) ? bus.We0 : eg(1) ? bus.We1 : 1'b0});
        chk("ram_addr", {17'd0, bus.RAM_Addr},
            {17'd0, eg(0) ? bus.Addr0 : eg(1) ? bus.Addr1 : 15'd0});
        chk("ram_wdata", {24'd0, bus.RAM_Write_Data},
            {24'd0, eg(0) ? bus.Wdata0 : eg(1) ? bus.Wdata1 : 8'd0});
        chk("rvalid0", {31'd0, bus.Rvalid0}, {31'd0, m.rv0});
        chk("rvalid1", {31'd0, bus.Rvalid1}, {31'd0, m.rv1});
        if (m.rv0) chk("rdata0", {24'd0, bus.Rdata0}, {24'd0, m_rd0});
        if (m.rv1) chk("rdata1", {24'd0, bus.Rdata1}, {24'd0, m_rd1});
`ifdef RAM_ARB_STATS_EN
        chk("beat_cnt0", {16'd0, beat_cnt0}, {16'd0, m_bc0});
        chk("beat_cnt1", {16'd0, beat_cnt1}, {16'd0, m_bc1});
`endif
        g0_seen <= g0_seen + int'(bus.Gnt0);
        g1_seen <= g1_seen + int'(bus.Gnt1);
    end

    task automatic beat(input int n, input logic we, input logic [14:0] a, input logic [7:0] d,
                        output int w);
        if (n == 0) begin
            bus.Req0 = 1'b1; bus.We0 = we; bus.Addr0 = a; bus.Wdata0 = d;
        end else begin
            bus.Req1 = 1'b1; bus.We1 = we; bus.Addr1 = a; bus.Wdata1 = d;
        end
        w = 0;
        @(negedge clk);
        while (!(n == 0 ? bus.Gnt0 : bus.Gnt1) && w < 40) begin
            w++;
            @(negedge clk);
        end
        if (w >= 40) chk("grant_timeout", w, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drop(input int n);
        if (n == 0) begin bus.Req0 = 1'b0; bus.We0 = 1'b0; end
        else begin bus.Req1 = 1'b0; bus.We1 = 1'b0; end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w, wsum, base0, base1;
        bus.Req0 = 1'b0; bus.We0 = 1'b0; bus.Addr0 = '0; bus.Wdata0 = '0;
        bus.Req1 = 1'b0; bus.We1 = 1'b0; bus.Addr1 = '0; bus.Wdata1 = '0;
        tick();
        chk("rst_gnt0", {31'd0, bus.Gnt0}, 0);
        chk("rst_rvalid0", {31'd0, bus.Rvalid0}, 0);
        chk("rst_we", {31'd0, bus.RAM_Write_En}, 0);
        chk("rst_addr", {17'd0, bus.RAM_Addr}, 0);
        tick();
        rst = 1'b0;

        base1 = g1_seen;
        for (int i = 0; i < 4; i++) begin
            beat(0, 1'b1, 15'(i), 8'(160 + i), w);
            chk("t1_wait", w, i == 0 ? 1 : 0);
        end
        drop(0);
        tick();
        for (int i = 0; i < 4; i++) chk("t1_mem", {24'd0, mem[i]}, 160 + i);
        chk("t1_no_gnt1", g1_seen - base1, 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.Req1 = 1'b1; bus.We1 = 1'b0; bus.Addr1 = 15'h0021;
        beat(0, 1'b0, 15'h0020, 8'h00, w);
        chk("t2_tie_to_0", w, 1);
        drop(0);
        beat(1, 1'b0, 15'h0021, 8'h00, w);
        chk("t2_release_bubble", w, 1);
        drop(1);
        tick();

        bus.Req1 = 1'b1; bus.We1 = 1'b0; bus.Addr1 = 15'h0100;
        base0 = g0_seen;
        wsum = 0;
        for (int i = 0; i < 16; i++) begin
            beat(0, 1'b0, 15'(16 + i), 8'h00, w);
            wsum += w;
        end
        bus.Addr0 = 15'h0020;
        beat(1, 1'b0, 15'h0100, 8'h00, w);
        chk("t3_rotate_no_bubble", w, 0);
        chk("t3_burst_len", g0_seen - base0, 16);
        chk("t3_burst_wait", wsum, 1);
        drop(1);
        beat(0, 1'b0, 15'h0020, 8'h00, w);
        chk("t3_release_bubble", w, 1);
        drop(0);
        tick();

        beat(1, 1'b1, 15'h1234, 8'h55, w);
        drop(1);
        beat(0, 1'b0, 15'h1234, 8'h00, w);
        drop(0);
        @(negedge clk);
        chk("t4_rvalid0", {31'd0, bus.Rvalid0}, 1);
        chk("t4_rdata0", {24'd0, bus.Rdata0}, 32'h55);
        chk("t4_mem", {24'd0, mem[15'h1234]}, 32'h55);
        tick();

        beat(0, 1'b0, 15'h0030, 8'h00, w);
        beat(0, 1'b0, 15'h0031, 8'h00, w);
        chk("t5_pre_gnt0", {31'd0, bus.Gnt0}, 1);
        chk("t5_pre_rvalid0", {31'd0, bus.Rvalid0}, 1);
        rst = 1'b1;
        #1;
        chk("t5_gnt0", {31'd0, bus.Gnt0}, 0);
        chk("t5_gnt1", {31'd0, bus.Gnt1}, 0);
        chk("t5_rvalid0", {31'd0, bus.Rvalid0}, 0);
        chk("t5_rvalid1", {31'd0, bus.Rvalid1}, 0);
        chk("t5_we", {31'd0, bus.RAM_Write_En}, 0);
        chk("t5_addr", {17'd0, bus.RAM_Addr}, 0);
        tick();
        rst = 1'b0;
        bus.Req1 = 1'b1; bus.We1 = 1'b0; bus.Addr1 = 15'h0040;
        beat(0, 1'b0, 15'h0032, 8'h00, w);
        chk("t5_tie_to_0", w, 1);
        drop(0);
        drop(1);
        tick();

`ifdef RAM_ARB_STATS_EN
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        for (int i = 0; i < 20; i++) beat(0, 1'b1, 15'(512 + i), 8'(i), w);
        drop(0);
        for (int i = 0; i < 5; i++) beat(1, 1'b1, 15'(768 + i), 8'(i), w);
        drop(1);
        chk("stats_cnt0", {16'd0, beat_cnt0}, 20);
        chk("stats_cnt1", {16'd0, beat_cnt1}, 5);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("stats_clr0", {16'd0, beat_cnt0}, 0);
        chk("stats_clr1", {16'd0, beat_cnt1}, 0);
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
